hilo_div: RTL and testbench
===========================

# hilo_div

Iterative 32-bit divider with the architectural HI/LO register pair for the MIPS pipeline. It executes DIV/DIVU, writes the quotient to LO and the remainder to HI, and stalls the pipeline while the operation runs. It also takes the MTHI/MTLO writes and serves MFHI/MFLO reads using the decoder's `hiwrite`, `lowrite` and `hiorlo` controls. It sits beside the ALU in the EX stage.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. Only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  a DIV/DIVU is in EX with valid operands. Sampled only in IDLE.
- `signed_i`  in  1  1 = DIV (signed), 0 = DIVU. Sampled together with `start_i`.
- `a_i`  in  32  dividend (rs).
- `b_i`  in  32  divisor (rt).
- `annul_i`  in  1  flush of the in-flight divide (exception or flush).
- `hiwrite`  in  1  MTHI write enable.
- `lowrite`  in  1  MTLO write enable.
- `hi_i`  in  32  MTHI data.
- `lo_i`  in  32  MTLO data.
- `hiorlo`  in  1  read select: 0 = HI (MFHI), 1 = LO (MFLO).
- `stall_o`  out  1  pipeline stall request.
- `hilo_o`  out  32  `hiorlo ? lo_o : hi_o`, combinational.
- `hi_o`  out  32  HI register.
- `lo_o`  out  32  LO register.

## Operation
State machine states are IDLE, CALC and DONE.
- IDLE:
  - When `start_i` is 1, latch the operand magnitudes: `|a_i|` and `|b_i|` if `signed_i`, otherwise the raw values.
  - Latch the quotient-sign flag `a[31]^b[31]`, the remainder-sign flag `a[31]` (both forced to 0 when unsigned), and a divide-by-zero flag.
  - Clear the iteration counter and go to CALC.
- CALC:
  - Perform one restoring step per cycle on the 64-bit partial remainder {rem, quo}.
  - Shift left by 1. If `rem >= divisor`, subtract the divisor and set the quotient LSB to 1.
  - The counter runs 0..31. When the counter is 31, go to DONE.
- DONE:
  - Apply the sign fix-up: negate the quotient if the quotient-sign flag is set; negate the remainder if the remainder-sign flag is set.
  - At the clock edge, write LO = quotient and HI = remainder, then go to IDLE.
- Divide by zero gives LO = 0xFFFFFFFF and HI = `a_i` unmodified, for both signed and unsigned.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000 and HI = 0. This falls out of the magnitude path, so no special case is needed.
- `start_i` in CALC or DONE is ignored.
- `annul_i` in CALC or DONE returns to IDLE at the next edge. HI/LO are not written.
- `annul_i` in IDLE has priority over `start_i`: no divide starts.
- MTHI/MTLO:
  - `hiwrite` loads `hi_i` and `lowrite` loads `lo_i` at the edge, in any state.
  - Both may be asserted in the same cycle.
  - In DONE, the divide writeback wins over `hiwrite`/`lowrite` for the register it writes (both HI and LO).
- `hilo_o` has no write bypass. A value written at edge N is visible on `hilo_o` from cycle N+1.

## Timing
- Reset values:
  - State = IDLE, counter = 0.
  - `hi_o` = `lo_o` = 0, so `hilo_o` = 0.
  - `stall_o` = 0 while `start_i` is 0.
- `stall_o` = (IDLE & `start_i` & !`annul_i`) | CALC. It is combinational from `start_i` so the stall applies in the same cycle the DIV reaches EX.
- Cycle-level sequence, with the cycle where `start_i` is first seen in IDLE counted as cycle 0:
  - Cycles 1-32 are CALC; cycle 33 is DONE.
  - `stall_o` is high in cycles 0-32 (33 cycles) and low in cycle 33.
  - The DIV leaves EX at the same edge that writes HI/LO.
  - New HI/LO values are visible from cycle 34.
- A back-to-back DIV presented in cycle 33 is ignored, because the block is in DONE. It is re-presented from cycle 34, when the block is IDLE and `stall_o` asserts again.
- Asynchronous reset mid-operation aborts immediately: state goes to IDLE and HI/LO go to 0. Nothing is written afterwards.

## Test plan
- DIVU 100/7 -> `stall_o` high exactly 33 cycles; from cycle 34, `lo_o` = 14 and `hi_o` = 2.
- DIV -7/2 -> `lo_o` = 0xFFFFFFFD and `hi_o` = 0xFFFFFFFF. DIV 7/-2 -> `lo_o` = 0xFFFFFFFD and `hi_o` = 1.
- DIV 0x80000000/0xFFFFFFFF -> `lo_o` = 0x80000000 and `hi_o` = 0. DIVU 0x1234/0 -> `lo_o` = 0xFFFFFFFF and `hi_o` = 0x1234.
- Start DIVU 50/5, then assert `annul_i` in cycle 10 -> IDLE at cycle 11, `stall_o` low, HI/LO keep their prior values. A new start in cycle 12 completes normally.
- MTHI 0xAAAA and MTLO 0x5555 together -> `hilo_o` = 0xAAAA with `hiorlo` = 0 and 0x5555 with `hiorlo` = 1. `hiwrite` asserted in the DONE cycle of DIVU 9/4 -> HI = 1 and LO = 2 (divide wins).
- `resetn` pulsed low in cycle 15 of a divide -> `hi_o`/`lo_o` read 0 immediately and `stall_o` is low. No write occurs after reset is released.

Source files
------------

// File: rtl/hilo_div.sv
// HI/LO register pair with a 32-cycle restoring divider for DIV/DIVU.
// Stalls the pipeline from the cycle the DIV reaches EX until the DONE cycle.
//
// state  | meaning
// IDLE   | waiting for a DIV/DIVU; MTHI/MTLO serviced
// CALC   | one restoring shift/subtract step per cycle, 32 steps
// DONE   | sign fix-up and HI/LO writeback at the closing edge
module hilo_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             annul_i,
  input  logic             hiwrite,
  input  logic             lowrite,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             hiorlo,
  output logic             stall_o,
  output logic [WIDTH-1:0] hilo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;

  logic             go;
  logic             wb;
  logic             ge;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign go      = (state_q == S_IDLE) && start_i && !annul_i;
  assign stall_o = go || (state_q == S_CALC);

  // rem_q < divisor always holds, so the shifted value fits in WIDTH+1 bits
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign ge      = rem_sh >= {1'b0, dvs_q};
  assign rem_sub = rem_sh - {1'b0, dvs_q};

  assign quo_fix = qneg_q ? (~quo_q + 1'b1) : quo_q;
  assign rem_fix = rneg_q ? (~rem_q + 1'b1) : rem_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    wb      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          dvd_d   = a_i;
          rem_d   = '0;
          quo_d   = (signed_i && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
          dvs_d   = (signed_i && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;
          qneg_d  = signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          rneg_d  = signed_i && a_i[WIDTH-1];
          dz_d    = (b_i == '0);
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ge};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        wb      = !annul_i;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // divide writeback overrides MTHI/MTLO in the same cycle
  always_comb begin
    hi_d = hiwrite ? hi_i : hi_q;
    lo_d = lowrite ? lo_i : lo_q;
    if (wb) begin
      hi_d = dz_q ? dvd_q : rem_fix;
      lo_d = dz_q ? '1    : quo_fix;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign hilo_o = hiorlo ? lo_q : hi_q;

endmodule

// File: tb/tb_hilo_div.sv
// Bench for hilo_div: directed and random divides against an arithmetic
// reference, plus annul, MTHI/MTLO, back-to-back and mid-operation reset.
module tb_hilo_div;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i, signed_i, annul_i;
  logic [31:0] a_i, b_i;
  logic        hiwrite, lowrite;
  logic [31:0] hi_i, lo_i;
  logic        hiorlo;
  logic        stall_o;
  logic [31:0] hilo_o, hi_o, lo_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi, m_lo;

  hilo_div #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .signed_i(signed_i),
    .a_i(a_i), .b_i(b_i), .annul_i(annul_i), .hiwrite(hiwrite),
    .lowrite(lowrite), .hi_i(hi_i), .lo_i(lo_i), .hiorlo(hiorlo),
    .stall_o(stall_o), .hilo_o(hilo_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  function automatic void model_div(input logic [31:0] a, input logic [31:0] b,
                                    input logic sgn, output logic [31:0] q,
                                    output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Entered one step after a rising edge with the DUT idle; that cycle is cycle 0.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input bit keep_start, input bit mt_in_done, input string tag);
    logic [31:0] eq, er;
    int n_stall;
    model_div(a, b, sgn, eq, er);
    start_i = 1'b1; signed_i = sgn; a_i = a; b_i = b;
    #1;
    n_stall = stall_o ? 1 : 0;
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk); #1;
      if (keep_start) begin
        a_i = $urandom; b_i = $urandom; signed_i = ~sgn;
      end else begin
        start_i = 1'b0;
      end
      if (c == 33 && mt_in_done) begin
        hiwrite = 1'b1; lowrite = 1'b1; hi_i = $urandom; lo_i = $urandom;
      end
      #1;
      if (stall_o) n_stall++;
      if (c == 33) begin
        checks++;
        if (stall_o !== 1'b0) begin
          errors++; $display("FAIL %s done_stall got %b exp 0", tag, stall_o);
        end
        checks++;
        if (hi_o !== m_hi || lo_o !== m_lo) begin
          errors++;
          $display("FAIL %s early_write hi/lo got %h/%h exp %h/%h", tag, hi_o, lo_o, m_hi, m_lo);
        end
      end
    end
    @(posedge clk); #1;
    hiwrite = 1'b0; lowrite = 1'b0;
    hiorlo = 1'($urandom_range(0, 1));
    #1;
    checks++;
    if (n_stall != 33) begin
      errors++; $display("FAIL %s stall_cycles got %0d exp 33", tag, n_stall);
    end
    checks++;
    if (lo_o !== eq) begin
      errors++; $display("FAIL %s lo got %h exp %h (a=%h b=%h s=%b)", tag, lo_o, eq, a, b, sgn);
    end
    checks++;
    if (hi_o !== er) begin
      errors++; $display("FAIL %s hi got %h exp %h (a=%h b=%h s=%b)", tag, hi_o, er, a, b, sgn);
    end
    checks++;
    if (hilo_o !== (hiorlo ? eq : er)) begin
      errors++; $display("FAIL %s hilo got %h exp %h", tag, hilo_o, hiorlo ? eq : er);
    end
    m_hi = er; m_lo = eq;
  endtask

  task automatic test_reset();
    checks++;
    if (stall_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0 || hilo_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_in got stall=%b hi=%h lo=%h hilo=%h exp all 0", stall_o, hi_o, lo_o, hilo_o);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (stall_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_out got stall=%b hi=%h lo=%h exp all 0", stall_o, hi_o, lo_o);
    end
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_directed();
    do_div(32'd100, 32'd7, 1'b0, 0, 0, "divu_100_7");
    do_div(-32'sd7, 32'd2, 1'b1, 0, 0, "div_m7_2");
    do_div(32'd7, -32'sd2, 1'b1, 0, 0, "div_7_m2");
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0, "div_ovf");
    do_div(32'h0000_1234, 32'd0, 1'b0, 0, 0, "divu_by0");
    do_div(32'h8765_4321, 32'd0, 1'b1, 0, 0, "div_by0");
  endtask

  task automatic test_annul();
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd50; b_i = 32'd5;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL annul_stall got %b exp 0", stall_o);
    end
    checks++;
    if (hi_o !== m_hi || lo_o !== m_lo) begin
      errors++; $display("FAIL annul_keep hi/lo got %h/%h exp %h/%h", hi_o, lo_o, m_hi, m_lo);
    end
    @(posedge clk); #1;
    do_div(32'd50, 32'd5, 1'b0, 0, 0, "after_annul");
  endtask

  task automatic test_annul_idle();
    start_i = 1'b1; annul_i = 1'b1; a_i = 32'd99; b_i = 32'd3; signed_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL annul_idle_stall got %b exp 0", stall_o);
    end
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      errors++; $display("FAIL annul_idle_nostart got %b exp 0", stall_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mthilo();
    hiwrite = 1'b1; lowrite = 1'b1; hi_i = 32'h0000_AAAA; lo_i = 32'h0000_5555; hiorlo = 1'b0;
    #1;
    checks++;
    if (hilo_o !== m_hi) begin
      errors++; $display("FAIL no_bypass got %h exp %h", hilo_o, m_hi);
    end
    @(posedge clk); #1;
    hiwrite = 1'b0; lowrite = 1'b0;
    #1;
    checks++;
    if (hilo_o !== 32'h0000_AAAA) begin
      errors++; $display("FAIL mfhi got %h exp 0000aaaa", hilo_o);
    end
    hiorlo = 1'b1;
    #1;
    checks++;
    if (hilo_o !== 32'h0000_5555) begin
      errors++; $display("FAIL mflo got %h exp 00005555", hilo_o);
    end
    m_hi = 32'h0000_AAAA; m_lo = 32'h0000_5555;
    @(posedge clk); #1;
    do_div(32'd9, 32'd4, 1'b0, 0, 1, "div_wins");
  endtask

  task automatic test_back_to_back();
    do_div(32'd1000, 32'd33, 1'b0, 1, 0, "b2b_first");
    checks++;
    if (stall_o !== 1'b1) begin
      errors++; $display("FAIL b2b_restall got %b exp 1", stall_o);
    end
    do_div(-32'sd1000, 32'd33, 1'b1, 0, 0, "b2b_second");
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd12345; b_i = 32'd11;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got hi=%h lo=%h stall=%b exp 0/0/0", hi_o, lo_o, stall_o);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (hi_o !== 32'd0 || lo_o !== 32'd0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_after got hi=%h lo=%h stall=%b exp 0/0/0", hi_o, lo_o, stall_o);
    end
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        s;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if (i % 5 == 0) a = $urandom_range(0, 200);
      do_div(a, b, s, 0, 0, "random");
    end
  endtask

  initial begin
    resetn = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    a_i = '0; b_i = '0; hiwrite = 1'b0; lowrite = 1'b0; hi_i = '0; lo_i = '0;
    hiorlo = 1'b0;
    m_hi = '0; m_lo = '0;
    #2;
    test_reset();
    test_directed();
    test_annul();
    test_annul_idle();
    test_mthilo();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
